swap_monitor: RTL and testbench

Downstream checker for the nonblocking register-swap stage: each valid cycle it samples the swapped pair `a`/`b` and the derived `sum_in` (= `b`+1), and checks that the swap and increment rules hold. It counts good swaps, accumulates `sum_in`, and latches the first violation until cleared. The block sits directly after the swap registers and exposes registered status to the bench or to a debug bus.

---
 rtl/swap_monitor_if.sv | 12 +
 rtl/swap_monitor.sv | 139 +++++++++++++
 tb/tb_swap_monitor.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/swap_monitor_if.sv
// Sample bus from the swap-register stage into swap_monitor.
interface swap_monitor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum_in;

    modport master (output in_valid, a, b, sum_in);
    modport slave  (input  in_valid, a, b, sum_in);
endinterface

// File: rtl/swap_monitor.sv
// swap_monitor: checks that each valid sample is the swap of the previous one
// and that sum_in == b+1; counts good swaps, accumulates sum_in, and latches
// the first violation until reset/clear. All outputs come straight from flops.
module swap_monitor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    swap_monitor_if.slave    bus,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] swap_count,
    output logic [ACC_W-1:0] sum_acc,
    output logic             pass,
    output logic             err,
    output logic [1:0]       err_kind
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               pass_q, pass_d;
    logic               err_q, err_d;
    logic [1:0]         kind_q, kind_d;
    logic [WIDTH-1:0]   prev_a_q, prev_a_d;
    logic [WIDTH-1:0]   prev_b_q, prev_b_d;

    logic sum_ok;
    logic swap_ok;

    // Rule checks on the current sample; swap_ok only matters in CHECK.
    always_comb begin
        sum_ok  = (bus.sum_in == WIDTH'(bus.b + WIDTH'(1)));
        swap_ok = (bus.a == prev_b_q) && (bus.b == prev_a_q);
    end

    // Next-state and output logic; clear beats any sample in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        pass_d   = 1'b0;
        err_d    = err_q;
        kind_d   = kind_q;
        prev_a_d = prev_a_q;
        prev_b_d = prev_b_q;

        if (clear) begin
            state_d  = IDLE;
            cnt_d    = '0;
            acc_d    = '0;
            err_d    = 1'b0;
            kind_d   = 2'b00;
            prev_a_d = '0;
            prev_b_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (sum_ok) begin
                            prev_a_d = bus.a;
                            prev_b_d = bus.b;
                            acc_d    = acc_q + ACC_W'(bus.sum_in);
                            pass_d   = 1'b1;
                            state_d  = CHECK;
                        end else begin
                            err_d   = 1'b1;
                            kind_d  = 2'b10;
                            state_d = FAULT;
                        end
                    end
                end
                CHECK: begin
                    if (bus.in_valid) begin
                        if (swap_ok && sum_ok) begin
                            if (cnt_q != {CNT_W{1'b1}})
                                cnt_d = cnt_q + CNT_W'(1);
                            acc_d    = acc_q + ACC_W'(bus.sum_in);
                            prev_a_d = bus.a;
                            prev_b_d = bus.b;
                            pass_d   = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            kind_d  = {~sum_ok, ~swap_ok};
                            state_d = FAULT;
                        end
                    end
                end
                FAULT: begin
                    // Sticky: pass entered FAULT low, so holding it means 0.
                    pass_d = pass_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            pass_q   <= 1'b0;
            err_q    <= 1'b0;
            kind_q   <= 2'b00;
            prev_a_q <= '0;
            prev_b_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            kind_q   <= kind_d;
            prev_a_q <= prev_a_d;
            prev_b_q <= prev_b_d;
        end
    end

    // Outputs driven directly from flops.
    always_comb begin
        state      = state_q;
        swap_count = cnt_q;
        sum_acc    = acc_q;
        pass       = pass_q;
        err        = err_q;
        err_kind   = kind_q;
    end
endmodule

// File: tb/tb_swap_monitor.sv
// Bench for swap_monitor: directed test-plan sequences plus random traffic,
// checked every cycle against a behavioural model. A second instance with a
// 4-bit counter exercises saturation on the same stimulus.
module tb_swap_monitor;
    logic clk = 1'b0;
    logic reset;
    logic clear;
    always #5 clk = ~clk;

    swap_monitor_if #(.WIDTH(8)) bus ();

    logic [1:0]  state, state_s;
    logic [15:0] swap_count;
    logic [3:0]  swap_count_s;
    logic [15:0] sum_acc, sum_acc_s;
    logic        pass, pass_s, err, err_s;
    logic [1:0]  err_kind, err_kind_s;

    swap_monitor #(.WIDTH(8), .CNT_W(16), .ACC_W(16)) dut (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus),
        .state(state), .swap_count(swap_count), .sum_acc(sum_acc),
        .pass(pass), .err(err), .err_kind(err_kind)
    );

    swap_monitor #(.WIDTH(8), .CNT_W(4), .ACC_W(16)) dut_sat (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus),
        .state(state_s), .swap_count(swap_count_s), .sum_acc(sum_acc_s),
        .pass(pass_s), .err(err_s), .err_kind(err_kind_s)
    );

    int checks = 0;
    int errors = 0;
    int npass  = 0;

    // Model: m_cnt is the true (unbounded) swap count; saturation is applied
    // only when comparing against each instance's counter width.
    int m_state, m_cnt, m_acc, m_pass, m_err, m_kind, m_pa, m_pb;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit clr, input bit v,
                              input int a, input int b, input int s);
        bit sum_ok, swap_ok;
        if (rst || clr) begin
            m_state = 0; m_cnt = 0; m_acc = 0; m_pass = 0;
            m_err = 0; m_kind = 0; m_pa = 0; m_pb = 0;
            return;
        end
        m_pass = 0;
        if (m_state == 2 || !v) return;
        sum_ok  = (s == (b + 1) % 256);
        swap_ok = (a == m_pb) && (b == m_pa);
        if (m_state == 0) begin
            if (sum_ok) begin
                m_pa = a; m_pb = b; m_acc = (m_acc + s) % 65536;
                m_pass = 1; m_state = 1;
            end else begin
                m_err = 1; m_kind = 2; m_state = 2;
            end
        end else begin
            if (swap_ok && sum_ok) begin
                m_cnt++; m_acc = (m_acc + s) % 65536;
                m_pa = a; m_pb = b; m_pass = 1;
            end else begin
                m_err = 1; m_state = 2;
                m_kind = (sum_ok ? 0 : 2) + (swap_ok ? 0 : 1);
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit clr, input bit v,
                       input int a, input int b, input int s);
        reset = rst; clear = clr;
        bus.in_valid = v; bus.a = 8'(a); bus.b = 8'(b); bus.sum_in = 8'(s);
        @(posedge clk);
        model_step(rst, clr, v, a, b, s);
        #1;
        chk("state",      int'(state),        m_state);
        chk("swap_count", int'(swap_count),   (m_cnt > 65535) ? 65535 : m_cnt);
        chk("sum_acc",    int'(sum_acc),      m_acc);
        chk("pass",       int'(pass),         m_pass);
        chk("err",        int'(err),          m_err);
        chk("err_kind",   int'(err_kind),     m_kind);
        chk("sat_count",  int'(swap_count_s), (m_cnt > 15) ? 15 : m_cnt);
        chk("sat_pass",   int'(pass_s),       m_pass);
        if (pass) npass++;
    endtask

    task automatic smp(input int a, input int b, input int s);
        cyc(1'b0, 1'b0, 1'b1, a, b, s);
    endtask

    task automatic do_clear();
        cyc(1'b0, 1'b1, 1'b0, 0, 0, 0);
    endtask

    initial begin
        int a, b, s, r;
        reset = 1'b1; clear = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sum_in = '0;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b1, 5, 6, 7);
        chk("rst_state", int'(state), 0);
        chk("rst_err", int'(err), 0);

        // Normal stream
        npass = 0;
        smp(18, 0, 1); smp(0, 18, 19); smp(18, 0, 1); smp(0, 18, 19);
        chk("norm_state", int'(state), 1);
        chk("norm_cnt", int'(swap_count), 3);
        chk("norm_acc", int'(sum_acc), 40);
        chk("norm_npass", npass, 4);
        chk("norm_err", int'(err), 0);
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("norm_idle_pass", int'(pass), 0);

        // Swap mismatch, then FAULT ignores further samples
        do_clear();
        smp(18, 0, 1); smp(0, 17, 18);
        chk("swm_state", int'(state), 2);
        chk("swm_kind", int'(err_kind), 1);
        chk("swm_cnt", int'(swap_count), 0);
        chk("swm_acc", int'(sum_acc), 1);
        smp(0, 18, 19); smp(18, 0, 1); smp(9, 9, 10);
        chk("swm_hold_state", int'(state), 2);
        chk("swm_hold_kind", int'(err_kind), 1);
        chk("swm_hold_acc", int'(sum_acc), 1);

        // Sum mismatch on first sample, then both mismatches
        do_clear();
        smp(18, 0, 2);
        chk("sum_kind", int'(err_kind), 2);
        chk("sum_acc0", int'(sum_acc), 0);
        do_clear();
        smp(18, 0, 1); smp(0, 17, 5);
        chk("both_kind", int'(err_kind), 3);

        // Wrap-around and equal operands
        do_clear();
        smp(255, 255, 0); smp(255, 255, 0); smp(255, 255, 0);
        chk("wrap_cnt", int'(swap_count), 2);
        chk("wrap_acc", int'(sum_acc), 0);
        chk("wrap_err", int'(err), 0);
        smp(255, 255, 255);
        chk("wrap_kind", int'(err_kind), 2);

        // Saturation on the 4-bit instance
        do_clear();
        npass = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) smp(18, 0, 1); else smp(0, 18, 19);
        end
        chk("sat_hold", int'(swap_count_s), 15);
        chk("sat_full_cnt", int'(swap_count), 19);
        chk("sat_acc", int'(sum_acc_s), 200);
        chk("sat_npass", npass, 20);

        // Reset mid-run, then fresh first sample
        do_clear();
        smp(18, 0, 1); smp(0, 18, 19); smp(18, 0, 1);
        cyc(1'b1, 1'b0, 1'b1, 0, 18, 19);
        chk("mid_rst_cnt", int'(swap_count), 0);
        chk("mid_rst_acc", int'(sum_acc), 0);
        chk("mid_rst_state", int'(state), 0);
        smp(7, 3, 4);
        chk("after_rst_state", int'(state), 1);
        chk("after_rst_acc", int'(sum_acc), 4);
        chk("after_rst_cnt", int'(swap_count), 0);

        // Clear together with a valid good swap: sample dropped
        smp(3, 7, 8);
        cyc(1'b0, 1'b1, 1'b1, 7, 3, 4);
        chk("clr_drop_cnt", int'(swap_count), 0);
        chk("clr_drop_state", int'(state), 0);
        chk("clr_drop_pass", int'(pass), 0);

        // Random traffic, mostly legal swaps with occasional corruption
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (m_state == 1) begin
                a = m_pb; b = m_pa;
            end else begin
                a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) a = b;
            end
            s = (b + 1) % 256;
            if (r < 6) a = (a + 1 + int'($urandom_range(0, 200))) % 256;
            else if (r < 12) s = (s + 1 + int'($urandom_range(0, 200))) % 256;
            if (m_state == 2 && $urandom_range(0, 4) == 0)
                cyc(1'b0, 1'b1, $urandom_range(0, 1) == 1, a, b, s);
            else if ($urandom_range(0, 99) == 0)
                cyc(1'b1, 1'b0, 1'b1, a, b, s);
            else if ($urandom_range(0, 59) == 0)
                cyc(1'b0, 1'b1, 1'b1, a, b, s);
            else
                cyc(1'b0, 1'b0, $urandom_range(0, 4) != 0, a, b, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
